aidc_lite_comp_buf_ctrl: RTL and testbench

- Controller for the 16-entry x 64-bit compressed-data buffer: accepts variable-size compressed chunks (1..8 bytes) from the compressor and packs them contiguously into 64-bit words, using buffer byte-enables.
- Tracks buffer occupancy as a circular FIFO.
- Drains complete (or frame-final partial) words to a valid/ready output stream, tagged with last/byte-count.

---
 rtl/aidc_lite_comp_buf_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_aidc_lite_comp_buf_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidc_lite_comp_buf_ctrl.sv
// -----------------------------------------------------------------------------
// aidc_lite_comp_buf_ctrl
//
// Purpose:
//   Packs variable-size compressed chunks (1..8 bytes) contiguously into the
//   64-bit words of a DEPTH-entry compressed-data buffer (circular FIFO).
//   Complete words, and the final partial word of a frame, are read back and
//   presented on a valid/ready stream tagged with a byte count and last flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid_i/o_ready  chunk handshake
//   in_data_i           chunk bytes, byte k at [8k+7:8k]
//   in_nbytes_i         number of valid chunk bytes (legal 1..8)
//   in_last_i           chunk ends the frame; partial word is flushed
//   buf_wren_o ..       buffer write port (address, byte enables, data)
//   buf_rden_o ..       buffer read port; buf_rdata_i valid one cycle later
//   out_valid_o ..      packed word stream with byte count and last flag
//   occupancy_o         committed-unread entries plus the partial word
//   err_o               sticky: an illegal in_nbytes_i was presented
// -----------------------------------------------------------------------------
module aidc_lite_comp_buf_ctrl #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [63:0]   in_data_i,
    input  logic [3:0]    in_nbytes_i,
    input  logic          in_last_i,
    output logic          buf_wren_o,
    output logic [AW-1:0] buf_waddr_o,
    output logic [7:0]    buf_wbe_o,
    output logic [63:0]   buf_wdata_o,
    output logic          buf_rden_o,
    output logic [AW-1:0] buf_raddr_o,
    input  logic [63:0]   buf_rdata_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [63:0]   out_data_o,
    output logic [3:0]    out_nbytes_o,
    output logic          out_last_o,
    output logic [AW:0]   occupancy_o,
    output logic          err_o
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_SPILL  = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t        r_state;
    logic          r_run;          // low in reset and for the first cycle after
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [2:0]    r_off;          // byte offset of the next free lane
    logic [63:0]   r_spill_data;
    logic [3:0]    r_spill_nb;     // bytes spilling into the next word (1..7)
    logic          r_spill_last;
    logic          r_err;

    // Per-word metadata, indexed by buffer word address
    logic          r_side_last [0:DEPTH-1];
    logic [3:0]    r_side_nb   [0:DEPTH-1];

    // Read issued last cycle; its metadata travels alongside
    logic          r_rd_inflight;
    logic [3:0]    r_inf_nb;
    logic          r_inf_last;

    // Two-entry output queue; slot 0 is the head
    logic [1:0]    r_q_count;
    logic [63:0]   r_q0_data;
    logic [3:0]    r_q0_nb;
    logic          r_q0_last;
    logic [63:0]   r_q1_data;
    logic [3:0]    r_q1_nb;
    logic          r_q1_last;

    // ---------------------------------------------------------------------
    // Write-side combinational logic
    // ---------------------------------------------------------------------
    logic [AW:0]   w_committed;
    logic [AW:0]   w_used;
    logic          w_in_ready;
    logic          w_fire;
    logic          w_legal;
    logic          w_acc;
    logic          w_spill;
    logic [3:0]    w_sum;
    logic [3:0]    w_sum_m8;
    logic [127:0]  w_dbl;
    logic [63:0]   w_rot;
    logic [7:0]    w_acc_be;
    logic [7:0]    w_spill_be;
    logic          w_commit;
    logic [3:0]    w_commit_nb;
    logic          w_commit_last;

    assign w_committed = r_wr_ptr - r_rd_ptr;
    assign w_used      = w_committed + {{AW{1'b0}}, (r_off != 3'd0)};
    assign w_in_ready  = r_run && (r_state == ST_ACCEPT) && (w_used != FULL_COUNT);
    assign w_fire      = in_valid_i && w_in_ready;
    assign w_legal     = (in_nbytes_i != 4'd0) && (in_nbytes_i <= 4'd8);
    assign w_acc       = w_fire && w_legal;
    assign w_spill     = (r_state == ST_SPILL);
    assign w_sum       = {1'b0, r_off} + in_nbytes_i;
    assign w_sum_m8    = w_sum - 4'd8;

    // Rotate left by r_off bytes: the upper half of the doubled word shifted
    // left holds the wrapped-around bytes in the low lanes.
    assign w_dbl = {in_data_i, in_data_i} << {r_off, 3'b000};
    assign w_rot = w_dbl[127:64];

    // Lane enables: accept fills lanes off..min(7, s-1); spill fills 0..s-9
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign w_acc_be[gi]   = (4'(gi) >= {1'b0, r_off}) && (4'(gi) < w_sum);
            assign w_spill_be[gi] = (4'(gi) < r_spill_nb);
        end
    endgenerate

    // A word is committed when it fills up or the frame ends. In SPILL the
    // spilled word is committed only if it was the frame's final chunk.
    always_comb begin
        w_commit      = 1'b0;
        w_commit_nb   = 4'd0;
        w_commit_last = 1'b0;
        if (w_spill) begin
            w_commit      = r_spill_last;
            w_commit_nb   = r_spill_nb;
            w_commit_last = 1'b1;
        end else if (w_acc) begin
            w_commit      = (w_sum >= 4'd8) || in_last_i;
            w_commit_nb   = (w_sum >= 4'd8) ? 4'd8 : w_sum;
            w_commit_last = (w_sum > 4'd8) ? 1'b0 : in_last_i;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign buf_wren_o  = w_acc || w_spill;
    assign buf_waddr_o = r_wr_ptr[AW-1:0];
    assign buf_wbe_o   = w_spill ? w_spill_be   : (w_acc ? w_acc_be : 8'h00);
    assign buf_wdata_o = w_spill ? r_spill_data : (w_acc ? w_rot : 64'h0);
    assign occupancy_o = w_used;
    assign err_o       = r_err;

    // ---------------------------------------------------------------------
    // Write-side state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ACCEPT;
            r_wr_ptr     <= '0;
            r_off        <= 3'd0;
            r_spill_data <= 64'h0;
            r_spill_nb   <= 4'd0;
            r_spill_last <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (w_fire && !w_legal) begin
                        r_err <= 1'b1;
                    end
                    if (w_acc) begin
                        if (w_sum > 4'd8) begin
                            // Word completes with bytes left over; r_off keeps
                            // its value so the partial entry stays counted.
                            r_wr_ptr     <= r_wr_ptr + 1'b1;
                            r_spill_data <= w_rot;
                            r_spill_nb   <= w_sum_m8;
                            r_spill_last <= in_last_i;
                            r_state      <= ST_SPILL;
                        end else if ((w_sum == 4'd8) || in_last_i) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_off    <= 3'd0;
                        end else begin
                            r_off <= w_sum[2:0];
                        end
                    end
                end
                ST_SPILL: begin
                    if (r_spill_last) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_off    <= 3'd0;
                    end else begin
                        r_off <= r_spill_nb[2:0];
                    end
                    r_state <= ST_ACCEPT;
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

    // Metadata array: plain RAM, no reset needed since only committed
    // entries are ever read.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_side_last[r_wr_ptr[AW-1:0]] <= w_commit_last;
            r_side_nb[r_wr_ptr[AW-1:0]]   <= w_commit_nb;
        end
    end

    // ---------------------------------------------------------------------
    // Read side
    // ---------------------------------------------------------------------
    logic       w_pop;
    logic [2:0] w_q_after;
    logic       w_rden;
    logic [1:0] w_push_pos;
    logic       w_push_idx;

    assign w_pop      = out_valid_o && out_ready_i;
    // Entries the queue will hold after this cycle, counting the read already
    // in flight; a new read is only issued if there will be room for it.
    assign w_q_after  = {1'b0, r_q_count} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
    assign w_rden     = (w_committed != '0) && (w_q_after < 3'd2);
    assign w_push_pos = r_q_count - {1'b0, w_pop};
    assign w_push_idx = w_push_pos[0];

    assign buf_rden_o   = w_rden;
    assign buf_raddr_o  = r_rd_ptr[AW-1:0];
    assign out_valid_o  = (r_q_count != 2'd0);
    assign out_data_o   = r_q0_data;
    assign out_nbytes_o = r_q0_nb;
    assign out_last_o   = r_q0_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr      <= '0;
            r_rd_inflight <= 1'b0;
            r_inf_nb      <= 4'd0;
            r_inf_last    <= 1'b0;
            r_q_count     <= 2'd0;
        end else begin
            r_rd_inflight <= w_rden;
            if (w_rden) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_inf_nb   <= r_side_nb[r_rd_ptr[AW-1:0]];
                r_inf_last <= r_side_last[r_rd_ptr[AW-1:0]];
            end
            r_q_count <= w_q_after[1:0];
        end
    end

    // Head slot: takes the returning word if it lands at the head, otherwise
    // shifts up from slot 1 on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0_data <= 64'h0;
            r_q0_nb   <= 4'd0;
            r_q0_last <= 1'b0;
        end else if (r_rd_inflight && !w_push_idx) begin
            r_q0_data <= buf_rdata_i;
            r_q0_nb   <= r_inf_nb;
            r_q0_last <= r_inf_last;
        end else if (w_pop) begin
            r_q0_data <= r_q1_data;
            r_q0_nb   <= r_q1_nb;
            r_q0_last <= r_q1_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1_data <= 64'h0;
            r_q1_nb   <= 4'd0;
            r_q1_last <= 1'b0;
        end else if (r_rd_inflight && w_push_idx) begin
            r_q1_data <= buf_rdata_i;
            r_q1_nb   <= r_inf_nb;
            r_q1_last <= r_inf_last;
        end
    end

endmodule

// File: tb/tb_aidc_lite_comp_buf_ctrl.sv
module tb_aidc_lite_comp_buf_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [63:0]   in_data_i;
    logic [3:0]    in_nbytes_i;
    logic          in_last_i;
    logic          buf_wren_o;
    logic [AW-1:0] buf_waddr_o;
    logic [7:0]    buf_wbe_o;
    logic [63:0]   buf_wdata_o;
    logic          buf_rden_o;
    logic [AW-1:0] buf_raddr_o;
    logic [63:0]   buf_rdata_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [63:0]   out_data_o;
    logic [3:0]    out_nbytes_o;
    logic          out_last_o;
    logic [AW:0]   occupancy_o;
    logic          err_o;

    always #5 clk = ~clk;

    aidc_lite_comp_buf_ctrl #(.AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_nbytes_i (in_nbytes_i),
        .in_last_i   (in_last_i),
        .buf_wren_o  (buf_wren_o),
        .buf_waddr_o (buf_waddr_o),
        .buf_wbe_o   (buf_wbe_o),
        .buf_wdata_o (buf_wdata_o),
        .buf_rden_o  (buf_rden_o),
        .buf_raddr_o (buf_raddr_o),
        .buf_rdata_i (buf_rdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_nbytes_o(out_nbytes_o),
        .out_last_o  (out_last_o),
        .occupancy_o (occupancy_o),
        .err_o       (err_o)
    );

    // Buffer memory with byte enables and registered read
    logic [63:0] mem [0:(2**AW)-1];
    logic [63:0] rdata_r;
    always @(posedge clk) begin
        if (buf_wren_o) begin
            for (int b = 0; b < 8; b++) begin
                if (buf_wbe_o[b]) mem[buf_waddr_o][8*b +: 8] <= buf_wdata_o[8*b +: 8];
            end
        end
        if (buf_rden_o) rdata_r <= mem[buf_raddr_o];
    end
    assign buf_rdata_i = rdata_r;

    // ---------------- reference model: frame byte stream -> words ----------
    typedef struct {
        logic [63:0] d;
        int          nb;
        bit          last;
    } word_t;

    word_t        exp_q[$];
    byte unsigned m_bytes[$];
    bit           m_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_rdy = 0;

    // values seen at the most recent mid-cycle sample
    bit          s_acc, s_ready, s_wren, s_ovalid, s_olast;
    logic [3:0]  s_waddr, s_onb;
    logic [7:0]  s_wbe;
    logic [63:0] s_odata;
    logic [AW:0] s_occ;
    int          s_cyc;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_push(logic [63:0] d, int n, bit last);
        word_t w;
        for (int k = 0; k < n; k++) m_bytes.push_back(d[8*k +: 8]);
        while (m_bytes.size() >= 8) begin
            w.d = 64'h0;
            for (int k = 0; k < 8; k++) w.d[8*k +: 8] = m_bytes.pop_front();
            w.nb = 8;
            w.last = 1'b0;
            exp_q.push_back(w);
        end
        if (last) begin
            if (m_bytes.size() > 0) begin
                w.d = 64'h0;
                w.nb = m_bytes.size();
                for (int k = 0; k < w.nb; k++) w.d[8*k +: 8] = m_bytes.pop_front();
                w.last = 1'b1;
                exp_q.push_back(w);
            end else if (exp_q.size() > 0) begin
                exp_q[exp_q.size()-1].last = 1'b1;
            end
        end
    endtask

    // One clock cycle: sample and compare mid-cycle, advance the model,
    // then return just after the rising edge so inputs can change.
    task automatic tick();
        word_t       w;
        logic [63:0] mask;
        @(negedge clk);
        s_acc    = in_valid_i && in_ready_o;
        s_ready  = in_ready_o;
        s_wren   = buf_wren_o;
        s_waddr  = buf_waddr_o;
        s_wbe    = buf_wbe_o;
        s_ovalid = out_valid_o && out_ready_i;
        s_odata  = out_data_o;
        s_onb    = out_nbytes_o;
        s_olast  = out_last_o;
        s_occ    = occupancy_o;
        s_cyc    = cyc;
        if (!rst_n) begin
            exp_q.delete();
            m_bytes.delete();
            m_err = 1'b0;
        end else begin
            check("err_flag", err_o, m_err);
            check("ready_when_full", in_ready_o && (occupancy_o == 5'd16), 0);
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got data 0x%0h nbytes %0d, expected none", out_data_o, out_nbytes_o);
                end else begin
                    w = exp_q.pop_front();
                    mask = 64'h0;
                    for (int k = 0; k < w.nb; k++) mask[8*k +: 8] = 8'hFF;
                    check("word_data", out_data_o & mask, w.d);
                    check("word_nbytes", out_nbytes_o, w.nb);
                    check("word_last", out_last_o, w.last);
                end
            end
            if (s_acc) begin
                if (in_nbytes_i >= 4'd1 && in_nbytes_i <= 4'd8)
                    model_push(in_data_i, int'(in_nbytes_i), in_last_i);
                else
                    m_err = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rand_rdy) out_ready_i = ($urandom % 10) < 7;
    endtask

    task automatic send(logic [63:0] d, logic [3:0] n, bit last, output bit ok);
        in_data_i   = d;
        in_nbytes_i = n;
        in_last_i   = last;
        in_valid_i  = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (s_acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        rand_rdy    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic drain(int budget);
        out_ready_i = 1'b1;
        rand_rdy    = 1'b0;
        for (int t = 0; t < budget && exp_q.size() > 0; t++) tick();
        tick();
        tick();
        check("drained", exp_q.size(), 0);
    endtask

    bit ok;
    int tcommit, cnt;

    initial begin
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        in_data_i = 64'h0;
        in_nbytes_i = 4'd0;
        in_last_i = 1'b0;
        out_ready_i = 1'b1;
        #2;
        // reset state: every output low
        check("rst_ready", in_ready_o, 0);
        check("rst_wren", buf_wren_o, 0);
        check("rst_rden", buf_rden_o, 0);
        check("rst_ovalid", out_valid_o, 0);
        check("rst_occ", occupancy_o, 0);
        check("rst_err", err_o, 0);
        do_reset();

        // T1: eight 1-byte chunks packed into one word
        for (int i = 0; i < 8; i++) begin
            send(64'((i + 1) * 17), 4'd1, (i == 7), ok);
            check("t1_acc", ok, 1);
            check("t1_waddr", s_waddr, 0);
            check("t1_wbe", s_wbe, 64'(1 << i));
        end
        tcommit = s_cyc;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (s_ovalid) break;
        end
        check("t1_latency", s_cyc - tcommit, 3);
        check("t1_data", s_odata, 64'h8877665544332211);
        check("t1_nbytes", s_onb, 8);
        check("t1_last", s_olast, 1);

        // T2: chunk straddling a word boundary -> SPILL cycle
        do_reset();
        send(64'h0504030201, 4'd5, 1'b0, ok);
        check("t2_wbe_a", s_wbe, 8'h1F);
        send(64'hEEDDCCBBAA, 4'd5, 1'b0, ok);
        check("t2_waddr_b", s_waddr, 0);
        check("t2_wbe_b", s_wbe, 8'hE0);
        tick();
        check("t2_spill_ready", s_ready, 0);
        check("t2_spill_wren", s_wren, 1);
        check("t2_spill_waddr", s_waddr, 1);
        check("t2_spill_wbe", s_wbe, 8'h03);
        check("t2_spill_occ", s_occ, 2);
        send(64'h77, 4'd1, 1'b1, ok);
        check("t2_off2_waddr", s_waddr, 1);
        check("t2_off2_wbe", s_wbe, 8'h04);
        drain(40);

        // T3: short last chunk flushes a partial word
        do_reset();
        send(64'hFFFF_FFFF_FF33_2211, 4'd3, 1'b1, ok);
        check("t3_waddr", s_waddr, 0);
        check("t3_wbe", s_wbe, 8'h07);
        for (int t = 0; t < 10; t++) begin
            tick();
            if (s_ovalid) break;
        end
        check("t3_data", s_odata & 64'hFFFFFF, 64'h332211);
        check("t3_nbytes", s_onb, 3);
        check("t3_last", s_olast, 1);
        tick();
        check("t3_occ", occupancy_o, 0);
        send(64'h5A, 4'd1, 1'b1, ok);
        check("t3_next_waddr", s_waddr, 1);
        check("t3_next_wbe", s_wbe, 8'h01);
        drain(40);

        // T4: fill with the output stalled, then drain across the wrap
        do_reset();
        out_ready_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            send({$urandom, $urandom}, 4'd8, 1'b0, ok);
            if (!ok) break;
            cnt++;
        end
        check("t4_accepted", cnt, 18);
        check("t4_occ_full", occupancy_o, 16);
        check("t4_ready_low", in_ready_o, 0);
        out_ready_i = 1'b1;
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) tick();
        tick();
        check("t4_ready_back", in_ready_o, 1);
        check("t4_occ_empty", occupancy_o, 0);
        send(64'hBEEF, 4'd2, 1'b1, ok);
        drain(40);

        // T5: illegal byte counts are dropped and flagged
        do_reset();
        send(64'h1234, 4'd0, 1'b0, ok);
        check("t5_acc0", ok, 1);
        check("t5_nowrite0", s_wren, 0);
        tick();
        check("t5_err", err_o, 1);
        send(64'h5678, 4'd9, 1'b1, ok);
        check("t5_nowrite9", s_wren, 0);
        tick();
        tick();
        check("t5_err_sticky", err_o, 1);
        send(64'h332211, 4'd3, 1'b0, ok);
        check("t5_waddr", s_waddr, 0);
        check("t5_wbe", s_wbe, 8'h07);
        send(64'h998877665544, 4'd6, 1'b1, ok);
        drain(40);

        // T6: asynchronous reset in the middle of a SPILL cycle
        do_reset();
        send(64'h0504030201, 4'd5, 1'b0, ok);
        send(64'h0A09080706, 4'd5, 1'b0, ok);
        rst_n = 1'b0;
        #1;
        check("t6_ready", in_ready_o, 0);
        check("t6_wren", buf_wren_o, 0);
        check("t6_waddr", buf_waddr_o, 0);
        check("t6_wbe", buf_wbe_o, 0);
        check("t6_wdata", buf_wdata_o, 0);
        check("t6_rden", buf_rden_o, 0);
        check("t6_raddr", buf_raddr_o, 0);
        check("t6_ovalid", out_valid_o, 0);
        check("t6_odata", out_data_o, 0);
        check("t6_onb", out_nbytes_o, 0);
        check("t6_olast", out_last_o, 0);
        check("t6_occ", occupancy_o, 0);
        check("t6_err", err_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        send(64'h42, 4'd1, 1'b1, ok);
        check("t6_new_waddr", s_waddr, 0);
        check("t6_new_wbe", s_wbe, 8'h01);
        drain(40);

        // Randomized traffic with random output back-pressure
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [3:0] n;
            if (($urandom % 25) == 0) n = (($urandom % 2) == 0) ? 4'd0 : 4'(9 + $urandom % 7);
            else n = 4'(1 + $urandom % 8);
            send({$urandom, $urandom}, n, (($urandom % 6) == 0), ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL rand_send_timeout: chunk %0d not accepted within bound", i);
            end
            if (($urandom % 4) == 0) tick();
        end
        send({$urandom, $urandom}, 4'd4, 1'b1, ok);
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
